// File: rtl/w5300_reset_seq.sv
// W5300 hardware-reset and readiness sequencer: timed RESET# low pulse, PLL-lock wait,
// software-reset restart (deferred past any in-flight bus cycle) and gated interrupt pass-through.
module w5300_reset_seq #(
  parameter int unsigned RST_LOW_CYCLES = 16,
  parameter int unsigned LOCK_CYCLES    = 75000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic swrst,
  input  logic asl,
  input  logic wizintl,
  input  logic inten,
  output logic wizrstl,
  output logic wizready,
  output logic extintl
);

  typedef enum logic [1:0] {
    ASSERT,
    LOCK,
    READY,
    PEND
  } state_t;

  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             wizrstl_n, wizready_n, extintl_n;
  logic             asl_meta, asl_s, int_meta, int_s;
  logic             cnt_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asl_meta <= 1'b1;
      asl_s    <= 1'b1;
      int_meta <= 1'b1;
      int_s    <= 1'b1;
    end else begin
      asl_meta <= asl;
      asl_s    <= asl_meta;
      int_meta <= wizintl;
      int_s    <= int_meta;
    end
  end

  assign cnt_zero = (cnt == '0);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    wizrstl_n  = wizrstl;
    wizready_n = wizready;
    // Interrupt gate uses the registered ready flag, so it is held off while not ready.
    extintl_n  = ~(wizready & inten & ~int_s);
    unique case (state)
      ASSERT: begin
        wizrstl_n = 1'b0;
        if (cnt_zero) begin
          state_n   = LOCK;
          cnt_n     = LOCK_LOAD;
          wizrstl_n = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      LOCK: begin
        // A restart takes priority over lock completion on the same edge.
        if (swrst) begin
          state_n   = ASSERT;
          cnt_n     = RST_LOAD;
          wizrstl_n = 1'b0;
        end else if (cnt_zero) begin
          state_n    = READY;
          wizready_n = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      READY: begin
        if (swrst) begin
          if (asl_s) begin
            state_n    = ASSERT;
            cnt_n      = RST_LOAD;
            wizrstl_n  = 1'b0;
            wizready_n = 1'b0;
          end else begin
            state_n = PEND;
          end
        end
      end
      PEND: begin
        if (asl_s) begin
          state_n    = ASSERT;
          cnt_n      = RST_LOAD;
          wizrstl_n  = 1'b0;
          wizready_n = 1'b0;
        end
      end
      default: begin
        state_n = ASSERT;
        cnt_n   = RST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ASSERT;
      cnt      <= RST_LOAD;
      wizrstl  <= 1'b0;
      wizready <= 1'b0;
      extintl  <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wizrstl  <= wizrstl_n;
      wizready <= wizready_n;
      extintl  <= extintl_n;
    end
  end

endmodule

// File: tb/tb_w5300_reset_seq.sv
// Scoreboard bench for w5300_reset_seq: directed scenarios plus random traffic,
// checked against an elapsed-edge timing model of the reset sequence.
module tb_w5300_reset_seq;

  localparam int RST  = 4;
  localparam int LOCK = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic swrst = 1'b0;
  logic asl = 1'b1;
  logic wizintl = 1'b1;
  logic inten = 1'b0;
  logic wizrstl, wizready, extintl;

  w5300_reset_seq #(
    .RST_LOW_CYCLES(RST),
    .LOCK_CYCLES   (LOCK),
    .CNT_W         (17)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .swrst   (swrst),
    .asl     (asl),
    .wizintl (wizintl),
    .inten   (inten),
    .wizrstl (wizrstl),
    .wizready(wizready),
    .extintl (extintl)
  );

  always #5 clk = ~clk;

  // Model: e = edges elapsed since the current reset sequence began.
  int  e;
  bit  pend;
  bit  m_asl1, m_asl_s, m_int1, m_int_s;
  bit  exp_rstl, exp_ready, exp_ext;
  logic [2:0] expq[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic void model_reset();
    e = 0; pend = 0;
    m_asl1 = 1; m_asl_s = 1; m_int1 = 1; m_int_s = 1;
    exp_rstl = 0; exp_ready = 0; exp_ext = 1;
  endfunction

  function automatic void model_edge();
    bit ext_n, restart;
    if (rst) begin
      model_reset();
      return;
    end
    ext_n   = !(exp_ready && inten && !m_int_s);
    restart = 0;
    if (e < RST)             restart = 0;
    else if (e < RST + LOCK) restart = swrst;
    else if (pend)           restart = m_asl_s;
    else if (swrst) begin
      if (m_asl_s) restart = 1;
      else         pend = 1;
    end
    if (restart) begin
      e = 0; pend = 0;
    end else if (e < RST + LOCK) begin
      e++;
    end
    m_asl_s = m_asl1; m_asl1 = asl;
    m_int_s = m_int1; m_int1 = wizintl;
    exp_rstl  = (e >= RST);
    exp_ready = (e >= RST + LOCK);
    exp_ext   = ext_n;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    expq.push_back({exp_rstl, exp_ready, exp_ext});
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_swrst();
    swrst = 1'b1;
    step();
    swrst = 1'b0;
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 100 && e != target; i++) step();
    n_checks++;
    if (e != target) begin
      n_fail++;
      $display("FAIL run_until e=%0d required %0d", e, target);
    end
  endtask

  task automatic async_reset_pulse(input int hold);
    #2;
    rst = 1'b1;
    model_reset();
    expq.push_back({exp_rstl, exp_ready, exp_ext});
    steps(hold);
    rst = 1'b0;
  endtask

  // Monitor: one expectation per clock edge and per asynchronous reset assertion.
  always @(posedge clk or posedge rst) begin
    logic [2:0] ex;
    #1;
    if (expq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t got %b%b%b required an expectation", $time,
               wizrstl, wizready, extintl);
    end else begin
      ex = expq.pop_front();
      n_checks++;
      if (wizrstl !== ex[2]) begin
        n_fail++;
        $display("FAIL wizrstl t=%0t got %b required %b", $time, wizrstl, ex[2]);
      end
      n_checks++;
      if (wizready !== ex[1]) begin
        n_fail++;
        $display("FAIL wizready t=%0t got %b required %b", $time, wizready, ex[1]);
      end
      n_checks++;
      if (extintl !== ex[0]) begin
        n_fail++;
        $display("FAIL extintl t=%0t got %b required %b", $time, extintl, ex[0]);
      end
    end
  end

  initial begin
    model_reset();
    #2;
    rst = 1'b1;
    expq.push_back({exp_rstl, exp_ready, exp_ext});
    steps(2);
    rst = 1'b0;

    // Power-up with the interrupt asserted: extintl must stay high until ready.
    wizintl = 1'b0; inten = 1'b1;
    steps(20);
    wizintl = 1'b1;
    steps(4);

    // Software reset with the bus idle.
    asl = 1'b1;
    pulse_swrst();
    steps(RST + LOCK + 2);

    // Software reset during a bus cycle: deferred until asl rises.
    asl = 1'b0;
    steps(3);
    pulse_swrst();
    steps(4);
    pulse_swrst();
    asl = 1'b1;
    steps(RST + LOCK + 6);

    // Interrupt path and immediate masking by inten.
    wizintl = 1'b0;
    steps(5);
    inten = 1'b0;
    steps(2);
    inten = 1'b1;
    steps(3);
    wizintl = 1'b1;
    steps(4);

    // Restart five edges into LOCK.
    pulse_swrst();
    run_until(RST + 5);
    pulse_swrst();
    steps(RST + LOCK + 2);

    // swrst on the edge where LOCK completes.
    pulse_swrst();
    run_until(RST + LOCK - 1);
    pulse_swrst();
    steps(RST + LOCK + 2);

    // Asynchronous reset mid-LOCK, then power-up timing again.
    pulse_swrst();
    run_until(RST + 3);
    async_reset_pulse(1);
    steps(RST + LOCK + 2);

    // Asynchronous reset while PEND.
    asl = 1'b0;
    steps(3);
    pulse_swrst();
    steps(2);
    async_reset_pulse(2);
    asl = 1'b1;
    steps(RST + LOCK + 2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) asl = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) wizintl = ~wizintl;
      if ($urandom_range(0, 15) == 0) inten = ~inten;
      swrst = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 499) == 0) begin
        swrst = 1'b0;
        async_reset_pulse($urandom_range(1, 3));
      end else begin
        step();
      end
    end
    swrst = 1'b0;
    steps(2);

    #2;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d required 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
